// File: rtl/jb_dbgbuf_capture_ctrl.sv
// Debug-buffer port B capture sequencer: waits for a trigger, then streams each enabled IQ
// source in turn into contiguous RAM segments as packed 64-bit {odd, even} sample pairs.
module jb_dbgbuf_capture_ctrl #(
    parameter int N_SRC  = 8,
    parameter int ADDR_W = 15,
    parameter int SRC_W  = $clog2(N_SRC)
) (
    input  logic                  clk_3x,
    input  logic                  dbgbuf_portb_rst,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic [1:0]            cfg_trig_sel,
    input  logic [N_SRC-1:0]      cfg_src_mask,
    input  logic [ADDR_W-1:0]     cfg_num_words,
    input  logic                  frm_mrkr,
    input  logic                  sync_5ms,
    input  logic [N_SRC*32-1:0]   s_tdata,
    input  logic [N_SRC-1:0]      s_tvalid,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [63:0]           ram_wdata,
    output logic                  stat_busy,
    output logic                  stat_done,
    output logic                  stat_err,
    output logic [SRC_W-1:0]      stat_cur_src
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_NEXT    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [1:0] TRIG_FRM  = 2'd1;
    localparam logic [1:0] TRIG_SYNC = 2'd2;

    // {found, index} of the lowest set mask bit at or above 'from'
    function automatic logic [SRC_W:0] find_set(input logic [N_SRC-1:0] mask, input int from);
        logic [SRC_W:0] res;
        res = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            res = (mask[i] && (i >= from)) ? {1'b1, SRC_W'(i)} : res;
        end
        return res;
    endfunction

    state_t              state_q, state_d;
    logic [N_SRC-1:0]    mask_q, mask_d;
    logic [ADDR_W-1:0]   words_q, words_d;
    logic [1:0]          trig_sel_q, trig_sel_d;
    logic [SRC_W-1:0]    cur_src_q, cur_src_d;
    logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic                half_q, half_d;
    logic [31:0]         low_q, low_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [63:0]         wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                frm_q, frm_prev_q, sync_q, sync_prev_q;

    logic [SRC_W:0]      first_src_s;
    logic [SRC_W:0]      next_src_s;
    logic                start_ok_s;
    logic [31:0]         sample_s;
    logic                valid_s;
    logic                trig_hit_s;
    logic                accept_s;
    logic                last_word_s;

    assign first_src_s = find_set(cfg_src_mask, 0);
    assign next_src_s  = find_set(mask_q, int'(cur_src_q) + 1);
    assign start_ok_s  = first_src_s[SRC_W] && (cfg_num_words != '0);
    assign accept_s    = (state_q == ST_CAPTURE) && valid_s;
    assign last_word_s = accept_s && half_q && ((word_cnt_q + ADDR_W'(1)) == words_q);

    // Select the sample stream of the source currently being captured
    always_comb begin
        sample_s = 32'd0;
        valid_s  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            sample_s = (SRC_W'(i) == cur_src_q) ? s_tdata[i*32 +: 32] : sample_s;
            valid_s  = (SRC_W'(i) == cur_src_q) ? s_tvalid[i] : valid_s;
        end
    end

    // Trigger qualifier: rising edge of the registered level, or always for immediate mode
    always_comb begin
        case (trig_sel_q)
            TRIG_FRM:  trig_hit_s = frm_q & ~frm_prev_q;
            TRIG_SYNC: trig_hit_s = sync_q & ~sync_prev_q;
            default:   trig_hit_s = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk_3x or posedge dbgbuf_portb_rst) begin
        if (dbgbuf_portb_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything including a simultaneous start
    always_comb begin
        state_d = state_q;
        if (cfg_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: state_d = cfg_start ? (start_ok_s ? ST_WAIT : ST_DONE) : state_q;
                ST_WAIT:          state_d = trig_hit_s ? ST_CAPTURE : ST_WAIT;
                ST_CAPTURE:       state_d = last_word_s ? ST_NEXT : ST_CAPTURE;
                ST_NEXT:          state_d = next_src_s[SRC_W] ? ST_CAPTURE : ST_DONE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath and status next values
    always_comb begin
        mask_d     = mask_q;
        words_d    = words_q;
        trig_sel_d = trig_sel_q;
        cur_src_d  = cur_src_q;
        addr_cnt_d = addr_cnt_q;
        word_cnt_d = word_cnt_q;
        half_d     = half_q;
        low_d      = low_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        err_d      = err_q;
        if (cfg_abort) begin
            half_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (cfg_start && start_ok_s) begin
                        mask_d     = cfg_src_mask;
                        words_d    = cfg_num_words;
                        trig_sel_d = cfg_trig_sel;
                        cur_src_d  = first_src_s[SRC_W-1:0];
                        addr_cnt_d = '0;
                        word_cnt_d = '0;
                        half_d     = 1'b0;
                        done_d     = 1'b0;
                        err_d      = 1'b0;
                    end else if (cfg_start) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        done_d = done_q;
                    end
                end
                ST_CAPTURE: begin
                    if (accept_s && !half_q) begin
                        low_d  = sample_s;
                        half_d = 1'b1;
                    end else if (accept_s) begin
                        we_d       = 1'b1;
                        addr_d     = addr_cnt_q;
                        wdata_d    = {sample_s, low_q};
                        addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                        word_cnt_d = word_cnt_q + ADDR_W'(1);
                        half_d     = 1'b0;
                    end else begin
                        half_d = half_q;
                    end
                end
                ST_NEXT: begin
                    if (next_src_s[SRC_W]) begin
                        cur_src_d  = next_src_s[SRC_W-1:0];
                        word_cnt_d = '0;
                        half_d     = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
                default: begin
                    half_d = half_q;
                end
            endcase
        end
        busy_d = (state_d == ST_WAIT) || (state_d == ST_CAPTURE) || (state_d == ST_NEXT);
    end

    // Datapath, status and trigger-input registers
    always_ff @(posedge clk_3x or posedge dbgbuf_portb_rst) begin
        if (dbgbuf_portb_rst) begin
            mask_q      <= '0;
            words_q     <= '0;
            trig_sel_q  <= 2'd0;
            cur_src_q   <= '0;
            addr_cnt_q  <= '0;
            word_cnt_q  <= '0;
            half_q      <= 1'b0;
            low_q       <= 32'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 64'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            frm_q       <= 1'b0;
            frm_prev_q  <= 1'b0;
            sync_q      <= 1'b0;
            sync_prev_q <= 1'b0;
        end else begin
            mask_q      <= mask_d;
            words_q     <= words_d;
            trig_sel_q  <= trig_sel_d;
            cur_src_q   <= cur_src_d;
            addr_cnt_q  <= addr_cnt_d;
            word_cnt_q  <= word_cnt_d;
            half_q      <= half_d;
            low_q       <= low_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            frm_q       <= frm_mrkr;
            frm_prev_q  <= frm_q;
            sync_q      <= sync_5ms;
            sync_prev_q <= sync_q;
        end
    end

    assign ram_we       = we_q;
    assign ram_addr     = addr_q;
    assign ram_wdata    = wdata_q;
    assign stat_busy    = busy_q;
    assign stat_done    = done_q;
    assign stat_err     = err_q;
    assign stat_cur_src = cur_src_q;

endmodule
